// File: rtl/axil_reg_slave_pkg.sv
// Shared types and helpers for the AXI4-Lite register slave: response codes,
// write/read FSM state encodings and the byte-strobe merge.
package axil_reg_slave_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_A,
        W_HAVE_D,
        W_RESP
    } wstate_t;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } rstate_t;

    function automatic logic [31:0] strb_merge(input logic [31:0] old,
                                               input logic [31:0] data,
                                               input logic [3:0]  strb);
        logic [31:0] m;
        m = old;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) m[8*b +: 8] = data[8*b +: 8];
        end
        return m;
    endfunction

endpackage

// File: rtl/axil_reg_slave.sv
// AXI4-Lite slave holding NUM_REGS 32-bit registers, exported in parallel on regs_o.
// Define AXIL_REG_SLAVE_SLVERR_EN to answer out-of-range accesses with SLVERR instead of OKAY.
module axil_reg_slave
    import axil_reg_slave_pkg::*;
#(
    parameter int OFFSET_WIDTH = 12,
    parameter int NUM_REGS     = 4
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic [31:0]              s_axi_awaddr,
    input  logic [2:0]               s_axi_awprot,
    input  logic                     s_axi_awvalid,
    output logic                     s_axi_awready,
    input  logic [31:0]              s_axi_wdata,
    input  logic [3:0]               s_axi_wstrb,
    input  logic                     s_axi_wvalid,
    output logic                     s_axi_wready,
    output logic [1:0]               s_axi_bresp,
    output logic                     s_axi_bvalid,
    input  logic                     s_axi_bready,
    input  logic [31:0]              s_axi_araddr,
    input  logic [2:0]               s_axi_arprot,
    input  logic                     s_axi_arvalid,
    output logic                     s_axi_arready,
    output logic [31:0]              s_axi_rdata,
    output logic [1:0]               s_axi_rresp,
    output logic                     s_axi_rvalid,
    input  logic                     s_axi_rready,
    output logic [NUM_REGS*32-1:0]   regs_o
);

    localparam int IDX_W = OFFSET_WIDTH - 2;
    localparam logic [IDX_W:0] NREGS = (IDX_W+1)'(NUM_REGS);
`ifdef AXIL_REG_SLAVE_SLVERR_EN
    localparam logic [1:0] OOR_RESP = RESP_SLVERR;
`else
    localparam logic [1:0] OOR_RESP = RESP_OKAY;
`endif

    logic [NUM_REGS-1:0][31:0] r_regs;
    wstate_t          r_wstate, w_wstate_nxt;
    rstate_t          r_rstate, w_rstate_nxt;
    logic [IDX_W-1:0] r_awidx;
    logic [31:0]      r_wdata;
    logic [3:0]       r_wstrb;
    logic             r_awready, r_wready, r_bvalid, r_arready, r_rvalid;
    logic [1:0]       r_bresp, r_rresp;
    logic [31:0]      r_rdata;

    logic             w_aw_hs, w_w_hs, w_ar_hs, w_commit;
    logic [IDX_W-1:0] w_cidx, w_aridx;
    logic [31:0]      w_cdata, w_rd_word;
    logic [3:0]       w_cstrb;
    logic             w_c_inrange, w_ar_inrange;
    logic             w_unused;

    assign w_aw_hs = s_axi_awvalid & r_awready;
    assign w_w_hs  = s_axi_wvalid & r_wready;
    assign w_ar_hs = s_axi_arvalid & r_arready;

    // A commit takes whichever half arrived earlier from the latch, the other live.
    assign w_cidx  = (r_wstate == W_HAVE_A) ? r_awidx : s_axi_awaddr[OFFSET_WIDTH-1:2];
    assign w_cdata = (r_wstate == W_HAVE_D) ? r_wdata : s_axi_wdata;
    assign w_cstrb = (r_wstate == W_HAVE_D) ? r_wstrb : s_axi_wstrb;
    assign w_c_inrange = {1'b0, w_cidx} < NREGS;

    assign w_aridx      = s_axi_araddr[OFFSET_WIDTH-1:2];
    assign w_ar_inrange = {1'b0, w_aridx} < NREGS;

    always_comb begin
        w_rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_aridx == IDX_W'(i)) w_rd_word = r_regs[i];
        end
    end

    always_comb begin
        w_wstate_nxt = r_wstate;
        w_commit     = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                if (w_aw_hs && w_w_hs) begin
                    w_wstate_nxt = W_RESP;
                    w_commit     = 1'b1;
                end else if (w_aw_hs) begin
                    w_wstate_nxt = W_HAVE_A;
                end else if (w_w_hs) begin
                    w_wstate_nxt = W_HAVE_D;
                end
            end
            W_HAVE_A: if (w_w_hs) begin
                w_wstate_nxt = W_RESP;
                w_commit     = 1'b1;
            end
            W_HAVE_D: if (w_aw_hs) begin
                w_wstate_nxt = W_RESP;
                w_commit     = 1'b1;
            end
            W_RESP: if (s_axi_bready) w_wstate_nxt = W_IDLE;
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_RESP;
            R_RESP:  if (s_axi_rready) w_rstate_nxt = R_IDLE;
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_regs    <= '0;
            r_wstate  <= W_IDLE;
            r_rstate  <= R_IDLE;
            r_awidx   <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rresp   <= RESP_OKAY;
            r_rdata   <= '0;
        end else begin
            r_wstate  <= w_wstate_nxt;
            r_rstate  <= w_rstate_nxt;
            // Readys/valids are registered decodes of the next state.
            r_awready <= (w_wstate_nxt == W_IDLE) || (w_wstate_nxt == W_HAVE_D);
            r_wready  <= (w_wstate_nxt == W_IDLE) || (w_wstate_nxt == W_HAVE_A);
            r_bvalid  <= (w_wstate_nxt == W_RESP);
            r_arready <= (w_rstate_nxt == R_IDLE);
            r_rvalid  <= (w_rstate_nxt == R_RESP);
            if (w_aw_hs) r_awidx <= s_axi_awaddr[OFFSET_WIDTH-1:2];
            if (w_w_hs) begin
                r_wdata <= s_axi_wdata;
                r_wstrb <= s_axi_wstrb;
            end
            if (w_commit) r_bresp <= w_c_inrange ? RESP_OKAY : OOR_RESP;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_commit && (w_cidx == IDX_W'(i)))
                    r_regs[i] <= strb_merge(r_regs[i], w_cdata, w_cstrb);
            end
            // r_regs is read before the same-edge commit lands, so reads see the old value.
            if (w_ar_hs) begin
                r_rdata <= w_rd_word;
                r_rresp <= w_ar_inrange ? RESP_OKAY : OOR_RESP;
            end
        end
    end

    assign s_axi_awready = r_awready;
    assign s_axi_wready  = r_wready;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_bresp   = r_bresp;
    assign s_axi_arready = r_arready;
    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rresp   = r_rresp;
    assign s_axi_rdata   = r_rdata;
    assign regs_o        = r_regs;

    assign w_unused = &{1'b0, s_axi_awprot, s_axi_arprot,
                        s_axi_awaddr[31:OFFSET_WIDTH], s_axi_awaddr[1:0],
                        s_axi_araddr[31:OFFSET_WIDTH], s_axi_araddr[1:0]};

endmodule

// File: tb/tb_axil_reg_slave.sv
// Directed bench for axil_reg_slave: vector table of AXI-Lite transactions plus
// hand-written sequences for split AW/W ordering, backpressure and mid-transaction reset.
module tb_axil_reg_slave;

`ifdef AXIL_REG_SLAVE_SLVERR_EN
    localparam logic [1:0] OOR = 2'b10;
`else
    localparam logic [1:0] OOR = 2'b00;
`endif

    logic         aclk, areset;
    logic [31:0]  awaddr, wdata, araddr, rdata;
    logic [2:0]   awprot, arprot;
    logic [3:0]   wstrb;
    logic         awvalid, awready, wvalid, wready, bvalid, bready;
    logic         arvalid, arready, rvalid, rready;
    logic [1:0]   bresp, rresp;
    logic [127:0] regs_o;

    int checks = 0;
    int failures = 0;

    axil_reg_slave #(.OFFSET_WIDTH(12), .NUM_REGS(4)) dut (
        .aclk(aclk), .areset(areset),
        .s_axi_awaddr(awaddr), .s_axi_awprot(awprot), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arprot(arprot), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .regs_o(regs_o)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        logic        is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs[NV];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        bit aw_done, w_done, aw_hs, w_hs;
        int n;
        awaddr = a; awvalid = 1'b1;
        wdata = d; wstrb = s; wvalid = 1'b1;
        aw_done = 0; w_done = 0; n = 0;
        while (!(aw_done && w_done) && n < 50) begin
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            tick(); n++;
            if (aw_hs) begin aw_done = 1; awvalid = 1'b0; end
            if (w_hs)  begin w_done = 1;  wvalid = 1'b0; end
        end
        awvalid = 1'b0; wvalid = 1'b0;
        chk("write_addr_data_accept", {aw_done, w_done}, 2'b11);
        bready = 1'b1; n = 0;
        while (!bvalid && n < 50) begin tick(); n++; end
        chk("write_bvalid_seen", bvalid, 1'b1);
        resp = bresp;
        tick();
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
        bit ar_hs, done;
        int n;
        araddr = a; arvalid = 1'b1; done = 0; n = 0;
        while (!done && n < 50) begin
            ar_hs = arvalid && arready;
            tick(); n++;
            if (ar_hs) begin done = 1; arvalid = 1'b0; end
        end
        arvalid = 1'b0;
        chk("read_addr_accept", done, 1'b1);
        rready = 1'b1; n = 0;
        while (!rvalid && n < 50) begin tick(); n++; end
        chk("read_rvalid_seen", rvalid, 1'b1);
        d = rdata; resp = rresp;
        tick();
        rready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [1:0]  rsp;

        vecs[0]  = '{1'b1, 32'h44A00000, 32'h01234567, 4'hF, 32'h0,        2'b00};
        vecs[1]  = '{1'b1, 32'h44A00004, 32'h89ABCDEF, 4'hF, 32'h0,        2'b00};
        vecs[2]  = '{1'b0, 32'h44A00000, 32'h0,        4'h0, 32'h01234567, 2'b00};
        vecs[3]  = '{1'b0, 32'h44A00004, 32'h0,        4'h0, 32'h89ABCDEF, 2'b00};
        vecs[4]  = '{1'b1, 32'h00000000, 32'hFFFFFFFF, 4'hF, 32'h0,        2'b00};
        vecs[5]  = '{1'b1, 32'h00000000, 32'h00000000, 4'h5, 32'h0,        2'b00};
        vecs[6]  = '{1'b0, 32'h00000000, 32'h0,        4'h0, 32'hFF00FF00, 2'b00};
        vecs[7]  = '{1'b1, 32'h00000000, 32'h12345678, 4'h0, 32'h0,        2'b00};
        vecs[8]  = '{1'b0, 32'h00000000, 32'h0,        4'h0, 32'hFF00FF00, 2'b00};
        vecs[9]  = '{1'b1, 32'h44A00010, 32'hAAAAAAAA, 4'hF, 32'h0,        OOR};
        vecs[10] = '{1'b0, 32'h44A00010, 32'h0,        4'h0, 32'h00000000, OOR};
        vecs[11] = '{1'b0, 32'h44A0000C, 32'h0,        4'h0, 32'h00000000, 2'b00};
        vecs[12] = '{1'b1, 32'h0000000E, 32'hCAFEF00D, 4'hF, 32'h0,        2'b00};
        vecs[13] = '{1'b0, 32'h0000000C, 32'h0,        4'h0, 32'hCAFEF00D, 2'b00};

        areset = 1'b1;
        awaddr = '0; awprot = 3'b010; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arprot = 3'b010; arvalid = 1'b0; rready = 1'b0;

        repeat (3) tick();
        chk("reset_readys", {awready, wready, arready}, 3'b000);
        chk("reset_valids", {bvalid, rvalid, bresp, rresp}, 6'b0);
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_regs", regs_o, 128'h0);
        areset = 1'b0;
        tick();
        chk("post_reset_readys", {awready, wready, arready}, 3'b111);

        for (int i = 0; i < NV; i++) begin
            if (vecs[i].is_wr) begin
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, rsp);
                chk($sformatf("vec%0d_bresp", i), rsp, vecs[i].exp_resp);
            end else begin
                axi_read(vecs[i].addr, rd, rsp);
                chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_data);
                chk($sformatf("vec%0d_rresp", i), rsp, vecs[i].exp_resp);
            end
            if (i == 3) chk("regs_o_low64", regs_o[63:0], 64'h89ABCDEF_01234567);
        end
        chk("table_final_regs", regs_o, 128'hCAFEF00D_00000000_89ABCDEF_FF00FF00);

        // W three cycles ahead of AW
        wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
        tick(); wvalid = 1'b0;
        chk("w_first_have_d", {awready, wready, bvalid}, 3'b100);
        repeat (2) tick();
        chk("w_first_still_waiting", {awready, wready, bvalid}, 3'b100);
        awaddr = 32'h44A00008; awvalid = 1'b1;
        tick(); awvalid = 1'b0;
        chk("w_first_bvalid", {bvalid, bresp}, 3'b100);
        chk("w_first_reg2", regs_o[95:64], 32'hDEADBEEF);
        bready = 1'b1; tick(); bready = 1'b0;
        chk("w_first_b_done", {bvalid, awready, wready}, 3'b011);

        // AW three cycles ahead of W
        awaddr = 32'h44A00008; awvalid = 1'b1;
        tick(); awvalid = 1'b0;
        chk("aw_first_have_a", {awready, wready, bvalid}, 3'b010);
        repeat (2) tick();
        chk("aw_first_reg2_unchanged", regs_o[95:64], 32'hDEADBEEF);
        wdata = 32'h0BADF00D; wstrb = 4'hF; wvalid = 1'b1;
        tick(); wvalid = 1'b0;
        chk("aw_first_bvalid", {bvalid, bresp}, 3'b100);
        chk("aw_first_reg2", regs_o[95:64], 32'h0BADF00D);
        bready = 1'b1; tick(); bready = 1'b0;

        // Same-edge write+read of reg1, then both responses back-pressured
        awaddr = 32'h4; wdata = 32'h11112222; wstrb = 4'hF; araddr = 32'h4;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        chk("same_edge_read_old", rdata, 32'h89ABCDEF);
        chk("same_edge_reg1_new", regs_o[63:32], 32'h11112222);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk($sformatf("bp%0d_hs", c), {bvalid, rvalid, awready, wready, arready}, 5'b11000);
            chk($sformatf("bp%0d_data", c), {rdata, bresp, rresp}, {32'h89ABCDEF, 4'b0000});
        end
        bready = 1'b1; rready = 1'b1;
        tick();
        bready = 1'b0; rready = 1'b0;
        chk("bp_release", {bvalid, rvalid, awready, wready, arready}, 5'b00111);
        chk("pre_reset_regs", regs_o, 128'hCAFEF00D_0BADF00D_11112222_FF00FF00);

        // Reset with write in W_HAVE_A and read in R_RESP
        awaddr = 32'h4; awvalid = 1'b1; araddr = 32'h0; arvalid = 1'b1;
        tick();
        awvalid = 1'b0; arvalid = 1'b0;
        chk("mid_state", {awready, wready, bvalid, arready, rvalid}, 5'b01001);
        areset = 1'b1;
        tick();
        chk("mid_reset_regs", regs_o, 128'h0);
        chk("mid_reset_hs", {awready, wready, bvalid, arready, rvalid}, 5'b00000);
        chk("mid_reset_rdata", {rdata, rresp, bresp}, 36'h0);
        areset = 1'b0;
        tick();
        chk("mid_reset_release", {awready, wready, bvalid, arready, rvalid}, 5'b11010);
        axi_read(32'h4, rd, rsp);
        chk("after_reset_reg1", rd, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
